modem_ctl_sequencer: RTL and testbench

Sequences the icestick UART modem-control outputs DSR and CTS from the host's DTR/RTS requests and the receive-buffer occupancy. A free-running prescaler with carry-out, the same counter style used for the board blinkers, provides a slow timebase TICK. All debounce and delay timing is counted in TICKs. The block sits between the board pins and the UART receive path, replacing direct counter-driven DSR/CTS.

---
 rtl/modem_ctl_pkg.sv | 23 ++
 rtl/tick_prescaler.sv | 26 ++
 rtl/modem_ctl_sequencer.sv | 149 ++++++++++++++
 tb/tb_modem_ctl_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/modem_ctl_pkg.sv
// Shared types and defaults for the UART modem-control sequencer.
// State encodings match the debug LED decode on the board.
package modem_ctl_pkg;

    localparam int STATE_W = 3;
    localparam int HI_MARK_DEF = 12;
    localparam int LO_MARK_DEF = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_DSR = 3'd1,
        ST_READY    = 3'd2,
        ST_ACTIVE   = 3'd3,
        ST_THROTTLE = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler; tick_o is the registered carry-out,
// high for one cycle every 2**W cycles.
module tick_prescaler #(
    parameter int W = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    logic [W-1:0] cnt_q;
    logic         tick_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= &cnt_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/modem_ctl_sequencer.sv
// Sequences DSR/CTS from debounced DTR/RTS and receive-buffer level,
// with all timing counted in prescaler TICKs.
module modem_ctl_sequencer
    import modem_ctl_pkg::*;
#(
    parameter int PRESCALE_W = 16,
    parameter int LEVEL_W    = 5,
    parameter int DEBOUNCE   = 4,
    parameter int DSR_DELAY  = 8,
    parameter int HOLDOFF    = 2,
    parameter int HI_MARK    = HI_MARK_DEF,
    parameter int LO_MARK    = LO_MARK_DEF
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               DTR,
    input  logic               RTS,
    input  logic [LEVEL_W-1:0] RX_LEVEL,
    output logic               DSR,
    output logic               CTS,
    output logic               TICK,
    output logic [STATE_W-1:0] STATE
);

    localparam int CNT_MAX = max3(DSR_DELAY, DEBOUNCE, HOLDOFF);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]      DEB_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0]      DLY_LAST = CW'(DSR_DELAY - 1);
    localparam logic [CW-1:0]      HOLD_L   = CW'(HOLDOFF);
    localparam logic [LEVEL_W-1:0] HI_L     = LEVEL_W'(HI_MARK);
    localparam logic [LEVEL_W-1:0] LO_L     = LEVEL_W'(LO_MARK);

    logic tick;

    tick_prescaler #(
        .W(PRESCALE_W)
    ) u_presc (
        .clk_i (CLK),
        .rst_ni(RESETN),
        .tick_o(tick)
    );

    logic [1:0] pin;
    logic [1:0] db;

    assign pin = {RTS, DTR};

    for (genvar g = 0; g < 2; g++) begin : g_db
        logic          s1_q;
        logic          s2_q;
        logic          db_q;
        logic [CW-1:0] cnt_q;

        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                db_q  <= 1'b0;
                cnt_q <= '0;
            end else begin
                s1_q <= pin[g];
                s2_q <= s1_q;
                // Any return to the accepted level restarts the count.
                if (s2_q == db_q) begin
                    cnt_q <= '0;
                end else if (tick) begin
                    if (cnt_q == DEB_LAST) begin
                        db_q  <= s2_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end

        assign db[g] = db_q;
    end

    logic dtr_db;
    logic rts_db;

    assign dtr_db = db[0];
    assign rts_db = db[1];

    state_e        state_q, state_d;
    logic [CW-1:0] dly_q;
    logic [CW-1:0] hold_q;
    logic          dsr_q;
    logic          cts_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dtr_db) state_d = ST_WAIT_DSR;
            end
            ST_WAIT_DSR: begin
                if (tick && dly_q == DLY_LAST) state_d = ST_READY;
            end
            ST_READY: begin
                if (rts_db && RX_LEVEL < HI_L) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (RX_LEVEL >= HI_L) state_d = ST_THROTTLE;
                else if (!rts_db)     state_d = ST_READY;
            end
            ST_THROTTLE: begin
                if (!rts_db)
                    state_d = ST_READY;
                else if (hold_q >= HOLD_L && RX_LEVEL <= LO_L)
                    state_d = ST_ACTIVE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Losing DTR beats every other transition.
        if (state_q != ST_IDLE && !dtr_db) state_d = ST_IDLE;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            hold_q  <= '0;
            dsr_q   <= 1'b0;
            cts_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != ST_WAIT_DSR)
                dly_q <= '0;
            else if (tick)
                dly_q <= dly_q + 1'b1;
            if (state_q != ST_THROTTLE || state_d != ST_THROTTLE)
                hold_q <= '0;
            else if (tick && hold_q != HOLD_L)
                hold_q <= hold_q + 1'b1;
            dsr_q <= (state_d == ST_READY) || (state_d == ST_ACTIVE) ||
                     (state_d == ST_THROTTLE);
            cts_q <= (state_d == ST_ACTIVE);
        end
    end

    assign DSR   = dsr_q;
    assign CTS   = cts_q;
    assign TICK  = tick;
    assign STATE = state_q;

endmodule

// File: tb/tb_modem_ctl_sequencer.sv
// Directed bench for modem_ctl_sequencer with a cycle-level
// reference model and hand-computed TICK-count expectations.
module tb_modem_ctl_sequencer;

    localparam int PW     = 4;
    localparam int PERIOD = 1 << PW;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       DTR;
    logic       RTS;
    logic [4:0] RX_LEVEL;
    logic       DSR;
    logic       CTS;
    logic       TICK;
    logic [2:0] STATE;

    int n_chk  = 0;
    int n_pass = 0;

    modem_ctl_sequencer #(
        .PRESCALE_W(PW)
    ) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .DTR     (DTR),
        .RTS     (RTS),
        .RX_LEVEL(RX_LEVEL),
        .DSR     (DSR),
        .CTS     (CTS),
        .TICK    (TICK),
        .STATE   (STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out waiting", nm);
    endtask

    // Reference model: edges since reset, pin history, stable-tick counts.
    int m_cyc, m_state, m_dly, m_hold;
    int dph[2], rph[2];
    int m_dbv[2], m_dbn[2];

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_cyc = 0; m_state = 0; m_dly = 0; m_hold = 0;
            dph = '{0, 0}; rph = '{0, 0};
            m_dbv = '{0, 0}; m_dbn = '{0, 0};
        end else begin
            int  seen[2];
            int  odtr, orts, nxt, rx;
            bit  otick;
            otick = (m_cyc > 0) && (m_cyc % PERIOD == 0);
            rx = int'(RX_LEVEL);
            seen[0] = dph[1];
            seen[1] = rph[1];
            dph[1] = dph[0]; dph[0] = int'(DTR);
            rph[1] = rph[0]; rph[0] = int'(RTS);
            odtr = m_dbv[0];
            orts = m_dbv[1];
            for (int i = 0; i < 2; i++) begin
                if (seen[i] == m_dbv[i]) m_dbn[i] = 0;
                else if (otick) begin
                    m_dbn[i]++;
                    if (m_dbn[i] == 4) begin
                        m_dbv[i] = seen[i];
                        m_dbn[i] = 0;
                    end
                end
            end
            nxt = m_state;
            case (m_state)
                0: if (odtr != 0) begin nxt = 1; m_dly = 0; end
                1: if (otick) begin
                       m_dly++;
                       if (m_dly == 8) nxt = 2;
                   end
                2: if (orts != 0 && rx < 12) nxt = 3;
                3: if (rx >= 12) begin nxt = 4; m_hold = 0; end
                   else if (orts == 0) nxt = 2;
                4: if (orts == 0) nxt = 2;
                   else if (m_hold >= 2 && rx <= 4) nxt = 3;
                   else if (otick && m_hold < 2) m_hold++;
                default: nxt = 0;
            endcase
            if (m_state != 0 && odtr == 0) nxt = 0;
            m_state = nxt;
            m_cyc++;
        end
    end

    always @(negedge CLK) begin
        chk("cyc_state", int'(STATE), m_state);
        chk("cyc_dsr", int'(DSR), int'(m_state >= 2 && m_state <= 4));
        chk("cyc_cts", int'(CTS), int'(m_state == 3));
        chk("cyc_tick", int'(TICK), int'(m_cyc > 0 && m_cyc % PERIOD == 0));
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Leave the bench just after a TICK cycle so the next TICK is far off.
    task automatic align;
        bit ok;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (TICK) begin ok = 1; break; end
        end
        if (!ok) timeout("align");
        step();
    endtask

    task automatic ticks_until(input string nm, input int target,
                               output int nt);
        bit ok;
        ok = 0;
        nt = 0;
        for (int k = 0; k < 2000; k++) begin
            step();
            if (int'(STATE) == target) begin ok = 1; break; end
            if (TICK) nt++;
        end
        if (!ok) begin
            timeout(nm);
            nt = -1;
        end
    endtask

    initial begin
        int n;
        bit ok;
        RESETN = 1'b0; DTR = 1'b0; RTS = 1'b0; RX_LEVEL = '0;
        #22;
        chk("rst_state", int'(STATE), 0);
        chk("rst_dsr", int'(DSR), 0);
        chk("rst_cts", int'(CTS), 0);
        chk("rst_tick", int'(TICK), 0);
        RESETN = 1'b1;

        n = 0; ok = 0;
        for (int k = 0; k < 100; k++) begin
            step(); n++;
            if (TICK) begin ok = 1; break; end
        end
        if (!ok) timeout("first_tick");
        chk("first_tick_cycles", n, 16);
        step();
        chk("tick_width", int'(TICK), 0);
        n = 1; ok = 0;
        for (int k = 0; k < 100; k++) begin
            step(); n++;
            if (TICK) begin ok = 1; break; end
        end
        if (!ok) timeout("tick_period");
        chk("tick_period", n, 16);

        align();
        DTR = 1'b1;
        repeat (2 * PERIOD) step();
        DTR = 1'b0;
        repeat (100) step();
        chk("pulse_state", int'(STATE), 0);
        chk("pulse_dsr", int'(DSR), 0);

        align();
        DTR = 1'b1;
        ticks_until("dtr_debounce", 1, n);
        chk("dtr_debounce_ticks", n, 4);
        ticks_until("dsr_delay", 2, n);
        chk("dsr_delay_ticks", n, 8);
        chk("ready_dsr", int'(DSR), 1);
        chk("ready_cts", int'(CTS), 0);

        align();
        RTS = 1'b1;
        ticks_until("rts_debounce", 3, n);
        chk("rts_debounce_ticks", n, 4);
        chk("active_cts", int'(CTS), 1);
        RX_LEVEL = 5'd12;
        step();
        chk("hi_mark_state", int'(STATE), 4);
        chk("hi_mark_cts", int'(CTS), 0);
        chk("hi_mark_dsr", int'(DSR), 1);
        RX_LEVEL = 5'd4;
        ticks_until("holdoff", 3, n);
        chk("holdoff_ticks", n, 2);
        chk("unthrottle_cts", int'(CTS), 1);

        align();
        DTR = 1'b0;
        n = 0; ok = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (TICK) n++;
            if (n == 4) begin ok = 1; break; end
        end
        if (!ok) timeout("dtr_drop");
        step();
        RX_LEVEL = 5'd12;
        step();
        chk("drop_state", int'(STATE), 0);
        chk("drop_dsr", int'(DSR), 0);
        chk("drop_cts", int'(CTS), 0);

        RX_LEVEL = '0;
        align();
        DTR = 1'b1;
        ticks_until("reactivate", 3, n);
        chk("reactivate_ticks", n, 12);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            if (TICK) begin ok = 1; break; end
            step();
        end
        if (!ok) timeout("pre_reset_tick");
        #2;
        RESETN = 1'b0;
        #1;
        chk("async_dsr", int'(DSR), 0);
        chk("async_cts", int'(CTS), 0);
        chk("async_tick", int'(TICK), 0);
        chk("async_state", int'(STATE), 0);
        #20;
        RESETN = 1'b1;
        ticks_until("rst_debounce", 1, n);
        chk("rst_debounce_ticks", n, 4);
        ticks_until("rst_dsr_delay", 2, n);
        chk("rst_dsr_delay_ticks", n, 8);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
